// File: rtl/rv_imm_decode_stage_pkg.sv
// Shared constants for the decode-stage slice: XLEN, immediate-extender control
// codes, RV32 major opcodes and skid-buffer state encodings.
package rv_imm_decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] IMMEXT_CTRL_I = 3'd0;
    localparam logic [2:0] IMMEXT_CTRL_S = 3'd1;
    localparam logic [2:0] IMMEXT_CTRL_B = 3'd2;
    localparam logic [2:0] IMMEXT_CTRL_U = 3'd3;
    localparam logic [2:0] IMMEXT_CTRL_J = 3'd4;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] BUF_EMPTY = 2'd0;
    localparam logic [1:0] BUF_ONE   = 2'd1;
    localparam logic [1:0] BUF_FULL  = 2'd2;

endpackage

// File: rtl/rv_imm_ctrl_dec.sv
// Opcode classifier: picks the immediate format, whether the instruction uses an
// immediate at all, and flags opcodes outside the supported RV32 base set.
module rv_imm_ctrl_dec
    import rv_imm_decode_stage_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] immctrl,
    output logic       imm_used,
    output logic       illegal
);

    always_comb begin
        immctrl  = IMMEXT_CTRL_U;
        imm_used = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                immctrl  = IMMEXT_CTRL_I;
                imm_used = 1'b1;
            end
            OPC_STORE: begin
                immctrl  = IMMEXT_CTRL_S;
                imm_used = 1'b1;
            end
            OPC_BRANCH: begin
                immctrl  = IMMEXT_CTRL_B;
                imm_used = 1'b1;
            end
            OPC_JAL: begin
                immctrl  = IMMEXT_CTRL_J;
                imm_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                immctrl  = IMMEXT_CTRL_U;
                imm_used = 1'b1;
            end
            OPC_OP, OPC_FENCE: begin
                immctrl  = IMMEXT_CTRL_I;
                imm_used = 1'b0;
            end
            default: begin
                immctrl  = IMMEXT_CTRL_U;
                imm_used = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_immext.sv
// Immediate extender: builds the sign-extended XLEN immediate for the selected
// RV32 instruction format from instruction bits [31:7].
module rv_immext
    import rv_imm_decode_stage_pkg::*;
(
    input  logic [31:7]     instr,
    input  logic [2:0]      immctrl,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (immctrl)
            IMMEXT_CTRL_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMMEXT_CTRL_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMMEXT_CTRL_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMMEXT_CTRL_U: imm = {instr[31:12], 12'b0};
            IMMEXT_CTRL_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:       imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_imm_decode_stage.sv
// Registered decode slice: classifies the opcode, extends the immediate and holds
// the result in a valid/ready register backed by a one-entry skid buffer.
module rv_imm_decode_stage
    import rv_imm_decode_stage_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_dec_valid,
    output logic             o_dec_ready,
    input  logic [31:0]      i_dec_instr,
    input  logic [PC_W-1:0]  i_dec_pc,
    input  logic             i_dec_flush,
    output logic             o_dec_valid,
    input  logic             i_dec_ready,
    output logic [31:0]      o_dec_instr,
    output logic [PC_W-1:0]  o_dec_pc,
    output logic [XLEN-1:0]  o_dec_imm,
    output logic [2:0]       o_dec_immctrl,
    output logic             o_dec_imm_used,
    output logic             o_dec_illegal,
    input  logic             i_dec_cnt_clr,
    output logic [CNT_W-1:0] o_dec_stall_cnt
);

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic            accept;
    logic            fire;
    logic            load_main_new;
    logic            load_main_skid;
    logic            load_skid;

    logic [2:0]      dec_immctrl;
    logic            dec_imm_used;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_immctrl;
    logic            skid_imm_used;
    logic            skid_illegal;

    rv_imm_ctrl_dec u_ctrl_dec (
        .opcode   (i_dec_instr[6:0]),
        .immctrl  (dec_immctrl),
        .imm_used (dec_imm_used),
        .illegal  (dec_illegal)
    );

    rv_immext u_immext (
        .instr   (i_dec_instr[31:7]),
        .immctrl (dec_immctrl),
        .imm     (dec_imm)
    );

    assign o_dec_valid = (state != BUF_EMPTY);
    assign accept      = i_dec_valid & o_dec_ready;
    assign fire        = o_dec_valid & i_dec_ready;

    // Main takes a fresh beat when it is empty or draining this cycle; a beat
    // arriving while main stalls goes to the skid, which refills main on fire.
    assign load_main_new  = !i_dec_flush & accept & ((state == BUF_EMPTY) | fire);
    assign load_main_skid = !i_dec_flush & fire & (state == BUF_FULL);
    assign load_skid      = !i_dec_flush & accept & !fire & (state == BUF_ONE);

    always_comb begin
        next_state = state;
        if (i_dec_flush) begin
            next_state = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) next_state = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !fire)      next_state = BUF_FULL;
                    else if (fire && !accept) next_state = BUF_EMPTY;
                end
                BUF_FULL:  if (fire) next_state = BUF_ONE;
                default:   next_state = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= BUF_EMPTY;
            o_dec_ready <= 1'b0;
        end else begin
            state       <= next_state;
            o_dec_ready <= (next_state != BUF_FULL);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_dec_instr    <= '0;
            o_dec_pc       <= '0;
            o_dec_imm      <= '0;
            o_dec_immctrl  <= '0;
            o_dec_imm_used <= 1'b0;
            o_dec_illegal  <= 1'b0;
        end else if (load_main_new) begin
            o_dec_instr    <= i_dec_instr;
            o_dec_pc       <= i_dec_pc;
            o_dec_imm      <= dec_imm;
            o_dec_immctrl  <= dec_immctrl;
            o_dec_imm_used <= dec_imm_used;
            o_dec_illegal  <= dec_illegal;
        end else if (load_main_skid) begin
            o_dec_instr    <= skid_instr;
            o_dec_pc       <= skid_pc;
            o_dec_imm      <= skid_imm;
            o_dec_immctrl  <= skid_immctrl;
            o_dec_imm_used <= skid_imm_used;
            o_dec_illegal  <= skid_illegal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            skid_instr    <= '0;
            skid_pc       <= '0;
            skid_imm      <= '0;
            skid_immctrl  <= '0;
            skid_imm_used <= 1'b0;
            skid_illegal  <= 1'b0;
        end else if (load_skid) begin
            skid_instr    <= i_dec_instr;
            skid_pc       <= i_dec_pc;
            skid_imm      <= dec_imm;
            skid_immctrl  <= dec_immctrl;
            skid_imm_used <= dec_imm_used;
            skid_illegal  <= dec_illegal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_dec_stall_cnt <= '0;
        end else if (i_dec_cnt_clr) begin
            o_dec_stall_cnt <= '0;
        end else if (o_dec_valid && !i_dec_ready && (o_dec_stall_cnt != '1)) begin
            o_dec_stall_cnt <= o_dec_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_imm_decode_stage.sv
// Self-checking bench for rv_imm_decode_stage: directed test-plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_rv_imm_decode_stage;
    import rv_imm_decode_stage_pkg::*;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rstn;
    logic             i_dec_valid;
    logic             o_dec_ready;
    logic [31:0]      i_dec_instr;
    logic [PC_W-1:0]  i_dec_pc;
    logic             i_dec_flush;
    logic             o_dec_valid;
    logic             i_dec_ready;
    logic [31:0]      o_dec_instr;
    logic [PC_W-1:0]  o_dec_pc;
    logic [XLEN-1:0]  o_dec_imm;
    logic [2:0]       o_dec_immctrl;
    logic             o_dec_imm_used;
    logic             o_dec_illegal;
    logic             i_dec_cnt_clr;
    logic [CNT_W-1:0] o_dec_stall_cnt;

    rv_imm_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_dec_valid     (i_dec_valid),
        .o_dec_ready     (o_dec_ready),
        .i_dec_instr     (i_dec_instr),
        .i_dec_pc        (i_dec_pc),
        .i_dec_flush     (i_dec_flush),
        .o_dec_valid     (o_dec_valid),
        .i_dec_ready     (i_dec_ready),
        .o_dec_instr     (o_dec_instr),
        .o_dec_pc        (o_dec_pc),
        .o_dec_imm       (o_dec_imm),
        .o_dec_immctrl   (o_dec_immctrl),
        .o_dec_imm_used  (o_dec_imm_used),
        .o_dec_illegal   (o_dec_illegal),
        .i_dec_cnt_clr   (i_dec_cnt_clr),
        .o_dec_stall_cnt (o_dec_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    beat_t       model_q[$];
    logic        model_ready;
    logic [15:0] model_cnt;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] signExt(input logic [31:0] v, input int bits);
        logic [31:0] m;
        m = 32'd1 << (bits - 1);
        return (v ^ m) - m;
    endfunction

    // Reference decoder written from the ISA field layouts, not the RTL structure.
    task automatic refDecode(input logic [31:0] ins, output logic [31:0] imm,
                             output logic [2:0] ctrl, output logic used, output logic ill);
        logic [31:0] v;
        used = 1'b1;
        ill  = 1'b0;
        imm  = 32'd0;
        ctrl = IMMEXT_CTRL_U;
        case (ins & 32'h7F)
            32'h13, 32'h03, 32'h67, 32'h73: begin
                ctrl = IMMEXT_CTRL_I;
                imm  = signExt(ins >> 20, 12);
            end
            32'h23: begin
                ctrl = IMMEXT_CTRL_S;
                v    = ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
                imm  = signExt(v, 12);
            end
            32'h63: begin
                ctrl = IMMEXT_CTRL_B;
                v    = (((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
                     | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
                imm  = signExt(v, 13);
            end
            32'h6F: begin
                ctrl = IMMEXT_CTRL_J;
                v    = (((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hFF) << 12)
                     | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
                imm  = signExt(v, 21);
            end
            32'h37, 32'h17: begin
                ctrl = IMMEXT_CTRL_U;
                imm  = ins & 32'hFFFFF000;
            end
            32'h33, 32'h0F: begin
                ctrl = IMMEXT_CTRL_I;
                used = 1'b0;
                imm  = signExt(ins >> 20, 12);
            end
            default: begin
                used = 1'b0;
                ill  = 1'b1;
                imm  = ins & 32'hFFFFF000;
            end
        endcase
    endtask

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] e_imm;
        logic [2:0]  e_ctrl;
        logic        e_used;
        logic        e_ill;
        checkEq("valid", {31'd0, o_dec_valid}, {31'd0, model_q.size() != 0});
        checkEq("ready", {31'd0, o_dec_ready}, {31'd0, model_ready});
        checkEq("stall_cnt", {16'd0, o_dec_stall_cnt}, {16'd0, model_cnt});
        if (model_q.size() != 0) begin
            refDecode(model_q[0].instr, e_imm, e_ctrl, e_used, e_ill);
            checkEq("instr", o_dec_instr, model_q[0].instr);
            checkEq("pc", o_dec_pc, model_q[0].pc);
            checkEq("imm", o_dec_imm, e_imm);
            checkEq("immctrl", {29'd0, o_dec_immctrl}, {29'd0, e_ctrl});
            checkEq("imm_used", {31'd0, o_dec_imm_used}, {31'd0, e_used});
            checkEq("illegal", {31'd0, o_dec_illegal}, {31'd0, e_ill});
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic dready, input logic flush, input logic clr);
        logic  acc;
        logic  fir;
        logic  was_valid;
        beat_t b;
        i_dec_valid   = v;
        i_dec_instr   = ins;
        i_dec_pc      = pc;
        i_dec_ready   = dready;
        i_dec_flush   = flush;
        i_dec_cnt_clr = clr;
        #1;
        checkOutput();
        @(posedge i_clk);
        was_valid = (model_q.size() != 0);
        acc = v & model_ready;
        fir = was_valid & dready;
        if (fir) void'(model_q.pop_front());
        if (acc && !flush) begin
            b.instr = ins;
            b.pc    = pc;
            model_q.push_back(b);
        end
        if (flush) model_q.delete();
        if (clr) model_cnt = 16'd0;
        else if (was_valid && !dready && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        model_ready = (model_q.size() < 2);
        @(negedge i_clk);
    endtask

    task automatic modelReset();
        model_q.delete();
        model_ready = 1'b0;
        model_cnt   = 16'd0;
    endtask

    logic [6:0] opc_pool [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                  7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F, 7'h7F};

    initial begin
        logic [31:0] r;
        logic [31:0] pc;
        i_rstn        = 1'b0;
        i_dec_valid   = 1'b0;
        i_dec_instr   = '0;
        i_dec_pc      = '0;
        i_dec_flush   = 1'b0;
        i_dec_ready   = 1'b0;
        i_dec_cnt_clr = 1'b0;
        modelReset();

        // Reset state and ready rising on the first edge after release
        repeat (2) @(negedge i_clk);
        checkEq("rst_valid", {31'd0, o_dec_valid}, 32'd0);
        checkEq("rst_ready", {31'd0, o_dec_ready}, 32'd0);
        checkEq("rst_imm", o_dec_imm, 32'd0);
        checkEq("rst_instr", o_dec_instr, 32'd0);
        i_rstn = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        checkEq("rst_ready_rise", {31'd0, o_dec_ready}, 32'd1);

        // Single addi, then back-to-back sw / lui / jal with no bubbles
        applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, 1'b0);
        checkEq("addi_imm", o_dec_imm, 32'hFFFFFFFF);
        checkEq("addi_ctrl", {29'd0, o_dec_immctrl}, {29'd0, IMMEXT_CTRL_I});
        applyStimulus(1'b1, 32'h0020A423, 32'h104, 1'b1, 1'b0, 1'b0);
        checkEq("sw_imm", o_dec_imm, 32'h8);
        checkEq("sw_ctrl", {29'd0, o_dec_immctrl}, {29'd0, IMMEXT_CTRL_S});
        applyStimulus(1'b1, 32'h123452B7, 32'h108, 1'b1, 1'b0, 1'b0);
        checkEq("lui_imm", o_dec_imm, 32'h12345000);
        applyStimulus(1'b1, 32'h010000EF, 32'h10C, 1'b1, 1'b0, 1'b0);
        checkEq("jal_imm", o_dec_imm, 32'h10);
        checkEq("jal_ctrl", {29'd0, o_dec_immctrl}, {29'd0, IMMEXT_CTRL_J});

        // Illegal opcode followed by register-register add
        applyStimulus(1'b1, 32'h0000007F, 32'h110, 1'b1, 1'b0, 1'b0);
        checkEq("ill_flag", {31'd0, o_dec_illegal}, 32'd1);
        checkEq("ill_used", {31'd0, o_dec_imm_used}, 32'd0);
        applyStimulus(1'b1, 32'h00208033, 32'h114, 1'b1, 1'b0, 1'b0);
        checkEq("add_flag", {31'd0, o_dec_illegal}, 32'd0);
        checkEq("add_used", {31'd0, o_dec_imm_used}, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: three beats against a stalled consumer
        applyStimulus(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0, 1'b0);
        checkEq("bp_ready_low", {31'd0, o_dec_ready}, 32'd0);
        repeat (3) applyStimulus(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0, 1'b0);
        checkEq("bp_stall_cnt", {16'd0, o_dec_stall_cnt}, 32'd4);
        repeat (2) applyStimulus(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Flush while full with an incoming beat
        applyStimulus(1'b1, 32'h00400293, 32'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00500313, 32'h304, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600393, 32'h308, 1'b0, 1'b1, 1'b0);
        checkEq("flush_valid", {31'd0, o_dec_valid}, 32'd0);
        checkEq("flush_ready", {31'd0, o_dec_ready}, 32'd1);
        repeat (2) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

        // Random traffic against the reference model
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            applyStimulus(($urandom_range(0, 3) != 0), {r[31:7], opc_pool[$urandom_range(0, 11)]},
                          pc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0),
                          ($urandom_range(0, 60) == 0));
            pc = pc + 32'd4;
        end

        // Asynchronous reset while full
        applyStimulus(1'b1, 32'h00700413, 32'h400, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00800493, 32'h404, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00900513, 32'h408, 1'b0, 1'b0, 1'b0);
        i_rstn = 1'b0;
        #1;
        modelReset();
        checkEq("arst_valid", {31'd0, o_dec_valid}, 32'd0);
        checkEq("arst_ready", {31'd0, o_dec_ready}, 32'd0);
        checkEq("arst_cnt", {16'd0, o_dec_stall_cnt}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        checkEq("arst_ready_rise", {31'd0, o_dec_ready}, 32'd1);
        checkEq("arst_cnt_after", {16'd0, o_dec_stall_cnt}, 32'd0);
        applyStimulus(1'b1, 32'hFFF00093, 32'h500, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
